// File: rtl/cordic_pkg.sv
// Shared types, constants and arctangent lookup for the iterative CORDIC cosine engine.
package cordic_pkg;

   localparam int unsigned FIX_W   = 22;
   localparam int unsigned ATAN_IW = 5;

   typedef logic signed [FIX_W-1:0] fix_t;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ROTATE = 2'd1,
      DONE   = 2'd2
   } state_e;

   // Circular-mode gain compensation, 0.6072529 in Q2.20.
   localparam fix_t CORDIC_K = fix_t'(22'h09B74F);

   // round(atan(2^-i) * 2^20); from i=8 on the value equals 2^(20-i).
   function automatic fix_t atan_lut(input logic [ATAN_IW-1:0] idx);
      fix_t val;
      val = '0;
      case (idx)
         5'd0:  val = fix_t'(22'h0C90FE);
         5'd1:  val = fix_t'(22'h076B1A);
         5'd2:  val = fix_t'(22'h03EB6F);
         5'd3:  val = fix_t'(22'h01FD5C);
         5'd4:  val = fix_t'(22'h00FFAB);
         5'd5:  val = fix_t'(22'h007FF5);
         5'd6:  val = fix_t'(22'h003FFF);
         5'd7:  val = fix_t'(22'h002000);
         5'd8:  val = fix_t'(22'h001000);
         5'd9:  val = fix_t'(22'h000800);
         5'd10: val = fix_t'(22'h000400);
         5'd11: val = fix_t'(22'h000200);
         5'd12: val = fix_t'(22'h000100);
         5'd13: val = fix_t'(22'h000080);
         5'd14: val = fix_t'(22'h000040);
         5'd15: val = fix_t'(22'h000020);
         5'd16: val = fix_t'(22'h000010);
         5'd17: val = fix_t'(22'h000008);
         5'd18: val = fix_t'(22'h000004);
         5'd19: val = fix_t'(22'h000002);
         default: val = '0;
      endcase
      return val;
   endfunction

endpackage

// File: rtl/cordic_step.sv
// One combinational CORDIC micro-rotation in rotation mode, driven toward z = 0.
module cordic_step
   import cordic_pkg::*;
#(
   parameter int unsigned IW = 4
) (
   input  fix_t          x_i,
   input  fix_t          y_i,
   input  fix_t          z_i,
   input  logic [IW-1:0] i_i,
   output fix_t          x_o,
   output fix_t          y_o,
   output fix_t          z_o
);

   fix_t x_sh;
   fix_t y_sh;
   fix_t atan_v;

   always_comb begin
      x_sh   = x_i >>> i_i;
      y_sh   = y_i >>> i_i;
      atan_v = atan_lut(ATAN_IW'(i_i));
      // Negative residual angle rotates clockwise (d = -1).
      if (z_i[FIX_W-1]) begin
         x_o = x_i + y_sh;
         y_o = y_i - x_sh;
         z_o = z_i + atan_v;
      end else begin
         x_o = x_i - y_sh;
         y_o = y_i + x_sh;
         z_o = z_i - atan_v;
      end
   end

endmodule

// File: rtl/cordic_cos_iter.sv
// Iterative CORDIC cosine engine with valid/ready on both sides.
// Optional sine output enabled by defining CORDIC_SIN_EN.
module cordic_cos_iter
   import cordic_pkg::*;
#(
   parameter int unsigned ITERATIONS = 16
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [FIX_W-1:0]  in_angle,
   output logic              out_valid,
   input  logic              out_ready,
`ifdef CORDIC_SIN_EN
   output logic [FIX_W-1:0]  out_sin,
`endif
   output logic [FIX_W-1:0]  out_cos
);

   localparam int unsigned CNT_W = $clog2(ITERATIONS);
   localparam logic [CNT_W-1:0] LAST_I = CNT_W'(ITERATIONS - 1);

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   fix_t              x_q, x_d;
   fix_t              y_q, y_d;
   fix_t              z_q, z_d;
   logic              in_ready_q, in_ready_d;
   logic              out_valid_q, out_valid_d;
   fix_t              out_cos_q, out_cos_d;
`ifdef CORDIC_SIN_EN
   fix_t              out_sin_q, out_sin_d;
`endif

   fix_t              x_n, y_n, z_n;
   logic              accept;
   logic              last_step;

   cordic_step #(.IW(CNT_W)) u_step (
      .x_i (x_q),
      .y_i (y_q),
      .z_i (z_q),
      .i_i (cnt_q),
      .x_o (x_n),
      .y_o (y_n),
      .z_o (z_n)
   );

   assign accept    = in_valid & in_ready_q;
   assign last_step = (state_q == ROTATE) && (cnt_q == LAST_I);

   // State and datapath registers; reset aborts any job in flight.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         x_q         <= '0;
         y_q         <= '0;
         z_q         <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         out_cos_q   <= '0;
`ifdef CORDIC_SIN_EN
         out_sin_q   <= '0;
`endif
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         x_q         <= x_d;
         y_q         <= y_d;
         z_q         <= z_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         out_cos_q   <= out_cos_d;
`ifdef CORDIC_SIN_EN
         out_sin_q   <= out_sin_d;
`endif
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept)    state_d = ROTATE;
         ROTATE:  if (last_step) state_d = DONE;
         DONE:    if (out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Datapath and registered outputs, all derived from the next state.
   always_comb begin
      cnt_d       = cnt_q;
      x_d         = x_q;
      y_d         = y_q;
      z_d         = z_q;
      out_cos_d   = out_cos_q;
`ifdef CORDIC_SIN_EN
      out_sin_d   = out_sin_q;
`endif
      in_ready_d  = (state_d == IDLE);
      out_valid_d = (state_d == DONE);

      if (state_q == IDLE && accept) begin
         x_d   = CORDIC_K;
         y_d   = '0;
         z_d   = fix_t'(in_angle);
         cnt_d = '0;
      end else if (state_q == ROTATE) begin
         x_d   = x_n;
         y_d   = y_n;
         z_d   = z_n;
         cnt_d = last_step ? '0 : cnt_q + CNT_W'(1);
         if (last_step) begin
            out_cos_d = x_n;
`ifdef CORDIC_SIN_EN
            out_sin_d = y_n;
`endif
         end
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_cos   = out_cos_q;
`ifdef CORDIC_SIN_EN
   assign out_sin   = out_sin_q;
`endif

endmodule
